queue_capture_ctrl: RTL

Capture controller that drives the 384×8 circular RAM queue (write port and read address) and consumes its registered read data. Samples stream into the queue continuously once armed, wrapping at the last entry. A trigger freezes the buffer after a programmable number of post-trigger samples. A dump sequence then reads all entries back oldest-first as a valid-qualified byte stream.

---
 rtl/queue_capture_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/queue_capture_ctrl.sv
// queue_capture_ctrl
// Capture controller for a circular 8-bit RAM queue of ENTRIES entries.
// Once armed, every qualified sample is written at the write pointer, which
// wraps from ENTRIES-1 to 0. A trigger is accepted only after a full
// pre-trigger window has been written. The buffer freezes after tp
// post-trigger samples. A dump then reads all entries back, oldest first.
//
// Optional feature macro: QCTRL_TRIG_EDGE_EN
//   defined   : trig fires only on a rising edge across consecutive samples
//   undefined : trig is level-sensitive
//
// Ports
//   clk, rst        clock and asynchronous active-high reset
//   arm             pulse, starts a capture from IDLE (trig_pos latched here)
//   trig_pos        post-trigger sample count, clamped to [1, ENTRIES-1]
//   smpl_vld, smpl  sample strobe and data
//   trig            trigger, qualified by smpl_vld
//   rd_start        pulse, starts the dump from DONE
//   we/waddr/wdata  registered RAM write port
//   raddr           registered RAM read address
//   rdata           RAM read data, valid one clk after raddr
//   triggered       high from trigger acceptance until back in IDLE
//   capture_done    high while the frozen buffer waits in DONE
//   dump_vld        dump_data qualifier
//   dump_data       dumped byte
//   dump_done       one-cycle pulse after the last dumped byte
module queue_capture_ctrl #(
  parameter int unsigned ENTRIES = 384,
  parameter int unsigned AW      = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          arm,
  input  logic [AW-1:0] trig_pos,
  input  logic          smpl_vld,
  input  logic [7:0]    smpl,
  input  logic          trig,
  input  logic          rd_start,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [7:0]    wdata,
  output logic [AW-1:0] raddr,
  input  logic [7:0]    rdata,
  output logic          triggered,
  output logic          capture_done,
  output logic          dump_vld,
  output logic [7:0]    dump_data,
  output logic          dump_done
);

  typedef enum logic [2:0] {IDLE, ARMED, POST, DONE, DUMP} state_t;

  localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(ENTRIES);

  state_t        state, state_next;
  logic [AW-1:0] wptr;
  logic [AW-1:0] tp;
  logic [AW-1:0] post_cnt;
  logic [AW:0]   fill;
  logic [AW:0]   rd_cnt;
  logic          prev_trig;

  logic          capturing;
  logic          trig_hit;
  logic          accept;
  logic          post_last;
  logic          dump_end;
  logic [AW-1:0] wptr_inc;
  logic [AW-1:0] raddr_inc;
  logic [AW-1:0] tp_clamped;

  always_comb begin
    capturing = smpl_vld && (state == ARMED || state == POST);
    wptr_inc  = (wptr  == LAST) ? '0 : wptr  + AW'(1);
    raddr_inc = (raddr == LAST) ? '0 : raddr + AW'(1);

    if (trig_pos == '0)
      tp_clamped = AW'(1);
    else if (trig_pos > LAST)
      tp_clamped = LAST;
    else
      tp_clamped = trig_pos;

`ifdef QCTRL_TRIG_EDGE_EN
    trig_hit = trig && !prev_trig;
`else
    trig_hit = trig;
`endif

    // fill counts samples already written, so the sample arriving when
    // fill == ENTRIES-tp is the first one that still leaves a full window.
    accept    = (state == ARMED) && smpl_vld && trig_hit &&
                (fill >= (FULL - {1'b0, tp}));
    post_last = (state == POST) && smpl_vld && ((post_cnt + AW'(1)) == tp);
    dump_end  = (state == DUMP) && (rd_cnt == FULL);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arm)       state_next = ARMED;
      ARMED:   if (accept)    state_next = (tp == AW'(1)) ? DONE : POST;
      POST:    if (post_last) state_next = DONE;
      DONE:    if (rd_start)  state_next = DUMP;
      DUMP:    if (dump_end)  state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      raddr        <= '0;
      triggered    <= 1'b0;
      capture_done <= 1'b0;
      dump_vld     <= 1'b0;
      dump_done    <= 1'b0;
      wptr         <= '0;
      tp           <= '0;
      post_cnt     <= '0;
      fill         <= '0;
      rd_cnt       <= '0;
      prev_trig    <= 1'b1;
    end else begin
      we <= capturing;
      if (capturing) begin
        waddr <= wptr;
        wdata <= smpl;
        wptr  <= wptr_inc;
        if (fill != FULL)
          fill <= fill + 1'b1;
      end

      case (state)
        IDLE: begin
          wptr      <= '0;
          fill      <= '0;
          post_cnt  <= '0;
          prev_trig <= 1'b1;
          if (arm)
            tp <= tp_clamped;
        end
        ARMED: begin
          if (smpl_vld)
            prev_trig <= trig;
          if (accept) begin
            triggered <= 1'b1;
            post_cnt  <= AW'(1);
          end
        end
        POST: begin
          if (smpl_vld)
            post_cnt <= post_cnt + AW'(1);
        end
        DONE: begin
          if (rd_start) begin
            raddr  <= wptr;
            rd_cnt <= '0;
          end
        end
        DUMP: begin
          if (!dump_end) begin
            raddr  <= raddr_inc;
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: ;
      endcase

      // Delayed one clk from DONE entry so the final write has reached the RAM.
      capture_done <= (state == DONE) && !rd_start;
      dump_vld     <= (state == DUMP) && !dump_end;
      dump_done    <= dump_end;
      if (dump_end)
        triggered <= 1'b0;
    end
  end

  // rdata already carries the one-clk RAM latency; gating it keeps the byte
  // aligned with dump_vld without adding a second pipeline stage.
  always_comb begin
    dump_data = dump_vld ? rdata : '0;
  end

endmodule
